// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the GPU SRAM port arbiter (package gpu_sram_pkg).
package gpu_sram_pkg;
  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 1536;
  localparam int MAX_CLIENTS = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // First set bit of req at or above ptr, wrapping at n; 0 when req is empty.
  function automatic logic [2:0] rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                         input logic [2:0]             ptr,
                                         input logic [3:0]             n);
    logic [3:0] idx;
    rr_pick = 3'd0;
    for (int k = MAX_CLIENTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if ((4'(k) < n) && req[idx[2:0]]) rr_pick = idx[2:0];
    end
  endfunction
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client and SRAM signal bundle of the arbiter; master = arbiter side, slave = clients plus SRAM.
interface sram_port_arbiter_if
  import gpu_sram_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
);
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        c_read_enable;
  logic [NUM_CLIENTS-1:0]        c_write_enable;
  logic [NUM_CLIENTS*ADDR_W-1:0] c_address;
  logic [NUM_CLIENTS*DATA_W-1:0] c_write_data;
  logic [NUM_CLIENTS-1:0]        grant;
  logic [NUM_CLIENTS-1:0]        rvalid;
  logic [DATA_W-1:0]             rdata;
  logic                          read_enable;
  logic                          write_enable;
  logic [ADDR_W-1:0]             address;
  logic [DATA_W-1:0]             write_data;
  logic [DATA_W-1:0]             read_data;
  logic                          proto_err;

  modport master (
    input  req, c_read_enable, c_write_enable, c_address, c_write_data, read_data,
    output grant, rvalid, rdata, read_enable, write_enable, address, write_data, proto_err
  );

  modport slave (
    output req, c_read_enable, c_write_enable, c_address, c_write_data, read_data,
    input  grant, rvalid, rdata, read_enable, write_enable, address, write_data, proto_err
  );
endinterface

// File: rtl/sram_arb_rd_track.sv
// READ_LAT-deep (valid, client id) pipe that turns an issued SRAM read into the owner's rvalid strobe.
module sram_arb_rd_track
  import gpu_sram_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int READ_LAT    = 1,
  parameter int IDW         = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   rd_fire,
  input  logic [IDW-1:0]         rd_id,
  output logic [NUM_CLIENTS-1:0] rvalid
);
  localparam int SRW = READ_LAT * IDW;

  logic [READ_LAT-1:0] vld_sr;
  logic [SRW-1:0]      id_sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_sr <= '0;
      id_sr  <= '0;
    end else begin
      vld_sr <= READ_LAT'({vld_sr, rd_fire});
      id_sr  <= SRW'({id_sr, rd_id});
    end
  end

  assign rvalid = vld_sr[READ_LAT-1] ? (NUM_CLIENTS'(1) << id_sr[SRW-1 -: IDW]) : '0;
endmodule

// File: rtl/sram_port_arbiter.sv
// N-client round-robin arbiter for the shared SRAM port with bounded bursts and registered commands.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state | meaning
// IDLE  | no owner; one bubble cycle while the next winner is picked
// BUSY  | grant held by owner; each beat forwards its command to the SRAM
module sram_port_arbiter
  import gpu_sram_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_BURST   = 16,
  parameter int READ_LAT    = 1
) (
  input logic                 clk,
  input logic                 n_rst,
  sram_port_arbiter_if.master bus
);
  localparam int IDW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  arb_state_t             state;
  logic [IDW-1:0]         owner, rr_ptr, cmd_id, win, owner_inc, next_ptr;
  logic [CW-1:0]          beat_cnt, cnt_inc;
  logic [NUM_CLIENTS-1:0] grant_q, rvalid_w;
  logic                   rd_q, wr_q, err_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   own_rd, own_wr, beat, limit, rival;

  assign win       = IDW'(rr_pick(MAX_CLIENTS'(bus.req), 3'(rr_ptr), 4'(NUM_CLIENTS)));
  assign own_rd    = bus.c_read_enable[owner];
  assign own_wr    = bus.c_write_enable[owner];
  assign beat      = (state == BUSY) && bus.req[owner] && (own_rd || own_wr);
  assign cnt_inc   = (beat_cnt == CW'(MAX_BURST)) ? beat_cnt : beat_cnt + CW'(1);
  assign limit     = beat && (cnt_inc == CW'(MAX_BURST));
  assign owner_inc = (owner == IDW'(NUM_CLIENTS - 1)) ? '0 : owner + IDW'(1);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Burst rotation only yields to a lower-index requester; rr_ptr stays 0 so rr_pick scans from 0.
  logic [NUM_CLIENTS-1:0] lower_mask;
  assign lower_mask = (NUM_CLIENTS'(1) << owner) - NUM_CLIENTS'(1);
  assign rival      = |(bus.req & lower_mask);
  assign next_ptr   = '0;
`else
  logic [NUM_CLIENTS-1:0] own_mask;
  assign own_mask = NUM_CLIENTS'(1) << owner;
  assign rival    = |(bus.req & ~own_mask);
  assign next_ptr = owner_inc;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_id   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      if (beat) begin
        // Write wins when both enables are raised together.
        wr_q    <= own_wr;
        rd_q    <= own_rd & ~own_wr;
        addr_q  <= bus.c_address[int'(owner)*ADDR_W +: ADDR_W];
        wdata_q <= bus.c_write_data[int'(owner)*DATA_W +: DATA_W];
        cmd_id  <= owner;
        if (own_rd && own_wr) err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= BUSY;
            owner    <= win;
            grant_q  <= NUM_CLIENTS'(1) << win;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (!bus.req[owner] || (limit && rival)) begin
            state    <= IDLE;
            grant_q  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= next_ptr;
          end else if (limit) begin
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sram_arb_rd_track #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .READ_LAT    (READ_LAT),
    .IDW         (IDW)
  ) u_rd_track (
    .clk     (clk),
    .n_rst   (n_rst),
    .rd_fire (rd_q),
    .rd_id   (cmd_id),
    .rvalid  (rvalid_w)
  );

  assign bus.grant        = grant_q;
  assign bus.rvalid       = rvalid_w;
  assign bus.rdata        = bus.read_data;
  assign bus.read_enable  = rd_q;
  assign bus.write_enable = wr_q;
  assign bus.address      = addr_q;
  assign bus.write_data   = wdata_q;
  assign bus.proto_err    = err_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a cycle-level behavioural model.
module tb_sram_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .READ_LAT    (RL)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: owner of the grant (-1 none), beats in current burst, rotation pointer, cycle count
  int              m_owner, m_beats, m_ptr, cyc;
  logic            m_rd, m_wr, m_err;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   rd_word;
  int              rd_due[$];
  int              rd_id[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0;
    m_rd = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wdata = '0;
    rd_due.delete(); rd_id.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    int w;
    bit nrd, nwr, others;
    w = 0; nrd = 0; nwr = 0; others = 0;
    cyc++;
    if (m_owner >= 0) begin
      w = m_owner;
      if (bus.req[w] && (bus.c_read_enable[w] || bus.c_write_enable[w])) begin
        nwr = bus.c_write_enable[w];
        nrd = bus.c_read_enable[w] && !nwr;
        if (bus.c_read_enable[w] && bus.c_write_enable[w]) m_err = 1'b1;
        m_addr  = bus.c_address[w*AW +: AW];
        m_wdata = bus.c_write_data[w*DW +: DW];
        if (m_beats < MB) m_beats++;
      end
      for (int i = 0; i < N; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (i < w && bus.req[i]) others = 1;
`else
        if (i != w && bus.req[i]) others = 1;
`endif
      end
      if (!bus.req[w] || (m_beats == MB && others)) begin
        m_owner = -1;
        m_beats = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (w + 1) % N;
`endif
      end else if (m_beats == MB) begin
        m_beats = 0;
      end
    end else if (bus.req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_beats = 0;
    end
    m_rd = nrd;
    m_wr = nwr;
    if (nrd) begin
      rd_due.push_back(cyc + RL);
      rd_id.push_back(w);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_gnt;
    exp_rv = '0;
    while (rd_due.size() > 0 && rd_due[0] <= cyc) begin
      if (rd_due[0] == cyc) exp_rv[rd_id[0]] = 1'b1;
      void'(rd_due.pop_front());
      void'(rd_id.pop_front());
    end
    exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check_eq("grant",        64'(bus.grant),        64'(exp_gnt));
    check_eq("read_enable",  64'(bus.read_enable),  64'(m_rd));
    check_eq("write_enable", 64'(bus.write_enable), 64'(m_wr));
    check_eq("address",      64'(bus.address),      64'(m_addr));
    check_eq("write_data",   64'(bus.write_data),   64'(m_wdata));
    check_eq("rvalid",       64'(bus.rvalid),       64'(exp_rv));
    check_eq("proto_err",    64'(bus.proto_err),    64'(m_err));
    check_eq("rdata",        64'(bus.rdata),        64'(rd_word));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_outputs();
  endtask

  task automatic drive(input int i, input bit r, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]                   = r;
    bus.c_read_enable[i]         = rd;
    bus.c_write_enable[i]        = wr;
    bus.c_address[i*AW +: AW]    = a;
    bus.c_write_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_grant", 64'(bus.grant), 64'd0);
    check_eq("rst_err",   64'(bus.proto_err), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int cnt, run, maxrun;
    bus.req = '0; bus.c_read_enable = '0; bus.c_write_enable = '0;
    bus.c_address = '0; bus.c_write_data = '0;
    rd_word = '0; bus.read_data = '0;
    cyc = 0;
    model_reset();
    n_rst = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    n_rst = 1'b1;

    // single client, three reads
    drive(1, 1, 1, 0, 24'h10, '0);
    tick();
    check_eq("sc_grant", 64'(bus.grant), 64'h2);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, AW'(24'h10 + k), '0);
      tick();
      check_eq("sc_re",   64'(bus.read_enable), 64'd1);
      check_eq("sc_addr", 64'(bus.address), 64'(24'h10 + k));
      if (bus.rvalid[1]) cnt++;
    end
    drive(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.rvalid[1]) cnt++;
    end
    check_eq("sc_rvalid_cnt", 64'(cnt), 64'd3);

    // contention: client0 wins, drops after two beats
    drive(0, 1, 1, 0, 24'h100, '0);
    drive(1, 1, 1, 0, 24'h200, '0);
    tick();
    check_eq("ct_grant0", 64'(bus.grant), 64'h1);
    tick(); tick();
    drive(0, 0, 0, 0, '0, '0);
    tick();
    check_eq("ct_bubble", 64'(bus.grant), 64'h0);
    tick();
    check_eq("ct_grant1", 64'(bus.grant), 64'h2);

    // burst limit with both clients writing continuously
    run = 0; maxrun = 0;
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 0, 1, AW'($urandom()), rand_word());
      drive(1, 1, 0, 1, AW'($urandom()), rand_word());
      tick();
      if (bus.write_enable) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check_eq("burst_max_run", 64'(maxrun), 64'(MB));
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    repeat (3) tick();

    // lone burst: client1 alone keeps the grant past MAX_BURST
    drive(1, 1, 0, 1, 24'h3000, rand_word());
    tick();
    run = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 1, AW'(24'h3000 + k), rand_word());
      tick();
      if (bus.write_enable && bus.grant == 2'b10) run++;
    end
    check_eq("lone_run", 64'(run), 64'd10);
    drive(1, 0, 0, 0, '0, '0);
    repeat (2) tick();

    // protocol error: both enables from the granted client
    drive(0, 1, 1, 1, 24'h55, rand_word());
    tick();
    tick();
    check_eq("pe_we",  64'(bus.write_enable), 64'd1);
    check_eq("pe_re",  64'(bus.read_enable),  64'd0);
    check_eq("pe_err", 64'(bus.proto_err),    64'd1);
    drive(0, 0, 0, 0, '0, '0);
    repeat (3) tick();
    check_eq("pe_sticky", 64'(bus.proto_err), 64'd1);

    // reset mid-burst while client0 reads
    drive(0, 1, 1, 0, 24'h77, '0);
    repeat (3) tick();
    drive(1, 1, 1, 0, 24'h88, '0);
    pulse_reset();
    tick();
    check_eq("rst_next_grant", 64'(bus.grant), 64'h1);
    tick();
    check_eq("rst_no_rvalid", 64'(bus.rvalid), 64'h0);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        bit r, rd, wr;
        r  = ($urandom_range(7) == 0) ? !bus.req[i] : bus.req[i];
        rd = 1'($urandom_range(1));
        wr = !rd && ($urandom_range(2) == 0);
        if ($urandom_range(63) == 0) begin rd = 1; wr = 1; end
        drive(i, r, rd, wr, AW'($urandom()), rand_word());
      end
      rd_word = rand_word();
      bus.read_data = rd_word;
      if (k == 750) pulse_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised N-client arbiter for the single shared SRAM port of the 2D GPU pipeline; replaces the two-client enable-selected mux used between fill and alpha blend.
- Clients (fill, alpha blend, future texture/clear engines) raise requests. The arbiter grants one client at a time by round-robin, with bounded bursts.
- Drives registered SRAM command outputs and routes read-data valid strobes back to the owning client.

Parameters:
NUM_CLIENTS, 2, number of requesting engines (2..8)
ADDR_W, 24, SRAM address width
DATA_W, 1536, SRAM data word width
MAX_BURST, 16, max beats per grant before forced rotation (if others waiting)
READ_LAT, 1, cycles from read_enable output to valid read_data (1..4)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req  in  NUM_CLIENTS  per-client access request, held until its access completes
c_read_enable  in  NUM_CLIENTS  per-client read command
c_write_enable  in  NUM_CLIENTS  per-client write command
c_address  in  NUM_CLIENTS*ADDR_W  packed client addresses, client i at [i*ADDR_W +: ADDR_W]
c_write_data  in  NUM_CLIENTS*DATA_W  packed client write data
grant  out  NUM_CLIENTS  one-hot (or zero) registered grant
rvalid  out  NUM_CLIENTS  per-client read-data valid strobe
rdata  out  DATA_W  read data broadcast (= read_data)
read_enable  out  1  SRAM read
write_enable  out  1  SRAM write
address  out  ADDR_W  SRAM address
write_data  out  DATA_W  SRAM write data
read_data  in  DATA_W  SRAM read data
proto_err  out  1  sticky: granted client asserted read and write together

Behaviour:
- Reset (async, n_rst=0): grant=0, read_enable=0, write_enable=0, address=0, write_data=0, rvalid=0, proto_err=0, rr_ptr=0, beat_cnt=0, state=IDLE. Any in-flight read strobes are discarded.
- FSM states: IDLE, BUSY.
  - IDLE: if any req, choose winner w = first set req bit scanning from rr_ptr upward with wrap. Register grant[w]=1. Go to BUSY, beat_cnt=0.
  - BUSY: a beat is a cycle where grant[w] & req[w] & (c_read_enable[w] | c_write_enable[w]).
- Beat handling: on each beat, next cycle's outputs are read_enable/write_enable/address/write_data copied from client w (one-cycle command latency). With no beat, both enables are 0 next cycle; address and write_data hold.
- beat_cnt increments per beat (saturating at MAX_BURST).
- Release BUSY->IDLE, grant cleared next cycle, rr_ptr=(w+1) mod NUM_CLIENTS, when either:
  - req[w]=0, or
  - beat_cnt reaches MAX_BURST and any other req is set.
- If beat_cnt hits MAX_BURST with no other requester, grant is held and beat_cnt resets to 0.
- Re-arbitration costs exactly one bubble cycle, spent in IDLE with grant=0.
- Read return: shift register of depth READ_LAT carries (valid, client id). rvalid[id] is asserted in the cycle read_data is valid, READ_LAT cycles after the read_enable output. rdata=read_data combinationally. Strobes survive grant changes.
- Read and write asserted together by the granted client: write wins, read suppressed, proto_err set until reset.
- Commands from non-granted clients are ignored. Client id width is $clog2(NUM_CLIENTS), minimum 1.

Optional Feature:
- Macro SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is unused, held at 0.
- MAX_BURST rotation still applies, but only yields to a higher-priority (lower index) requester.
- Undefined: round-robin as above.

Decomposition:
- Package gpu_sram_pkg:
  - ADDR_W/DATA_W defaults
  - arb_state_t enum {IDLE, BUSY}
  - function rr_pick(req, ptr) returning the winner index.
- One sub-module, sram_arb_rd_track: the READ_LAT-deep valid/id shift register producing rvalid.

Test Plan:
- Reset mid-burst: client0 reading and n_rst pulsed low -> all outputs 0 the same cycle; no rvalid after release; next grant goes to client0 (rr_ptr=0).
- Single client: req[1]=1, 3 reads at addresses 0x10,0x11,0x12 -> grant=2'b10 one cycle after req; read_enable high 3 cycles with those addresses; rvalid[1] pulses 3 times, READ_LAT=1 after each.
- Contention: req=2'b11 from IDLE with rr_ptr=0 -> client0 granted. Client0 drops req after 2 beats -> one bubble, then grant=2'b10.
- Burst limit: MAX_BURST=4, both clients continuously writing -> grants alternate every 4 beats + 1 bubble; write_data matches the owning client's data each beat.
- Lone burst: MAX_BURST=4, only client1 requesting for 10 beats -> grant never drops, 10 consecutive write_enable cycles.
- Protocol error: granted client asserts both enables -> write_enable=1, read_enable=0, proto_err=1 and stays 1.
